// File: rtl/dds_cfg_pkg.sv
// Shared field codes, FSM encoding, widths and channel record for the DDS configuration scheduler.
package dds_cfg_pkg;

  localparam int FCW_W = 32;
  localparam int PCW_W = 10;
  localparam int AMP_W = 16;
  localparam int OFF_W = 16;

  typedef enum logic [1:0] {
    FLD_FCW    = 2'd0,
    FLD_PCW    = 2'd1,
    FLD_AMP    = 2'd2,
    FLD_OFFSET = 2'd3
  } field_e;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_SYNC = 2'd1,
    ST_APPLY     = 2'd2
  } state_e;

  typedef struct packed {
    logic [FCW_W-1:0] fcw;
    logic [PCW_W-1:0] pcw;
    logic [AMP_W-1:0] amp;
    logic [OFF_W-1:0] off;
  } chan_cfg_t;

  function automatic logic [31:0] cfg_field(input chan_cfg_t cfg, input field_e fld);
    logic [31:0] val;
    val = '0;
    case (fld)
      FLD_FCW:    val = cfg.fcw;
      FLD_PCW:    val = 32'(cfg.pcw);
      FLD_AMP:    val = 32'(cfg.amp);
      FLD_OFFSET: val = 32'(cfg.off);
      default:    val = '0;
    endcase
    return val;
  endfunction

endpackage

// File: rtl/dds_cfg_bank.sv
// One channel's shadow/active parameter pair with its dirty flag.
// DDS_CFG_READBACK_EN exposes the shadow record for host readback.
module dds_cfg_bank
  import dds_cfg_pkg::*;
#(
  parameter logic [OFF_W-1:0] RST_OFFSET = '0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  field_e      wr_field,
  input  logic [31:0] wr_data,
  input  logic        apply,
`ifdef DDS_CFG_READBACK_EN
  output chan_cfg_t   shadow,
`endif
  output chan_cfg_t   active,
  output logic        dirty
);

  localparam chan_cfg_t RST_CFG = '{fcw: '0, pcw: '0, amp: '0, off: RST_OFFSET};

  chan_cfg_t shadow_q;

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_q <= RST_CFG;
      active   <= RST_CFG;
      dirty    <= 1'b0;
    end else begin
      if (wr_en) begin
        dirty <= 1'b1;
        case (wr_field)
          FLD_FCW:    shadow_q.fcw <= wr_data[FCW_W-1:0];
          FLD_PCW:    shadow_q.pcw <= wr_data[PCW_W-1:0];
          FLD_AMP:    shadow_q.amp <= wr_data[AMP_W-1:0];
          FLD_OFFSET: shadow_q.off <= wr_data[OFF_W-1:0];
          default:    shadow_q     <= shadow_q;
        endcase
      end
      // Writes are only accepted in IDLE, so wr_en and apply never coincide.
      if (apply && dirty) begin
        active <= shadow_q;
        dirty  <= 1'b0;
      end
    end
  end

`ifdef DDS_CFG_READBACK_EN
  assign shadow = shadow_q;
`endif

endmodule

// File: rtl/dds_cfg_scheduler.sv
// Atomic configuration sequencer for the triangle DDS array: shadow writes, commit, synced apply.
// Optional feature macro DDS_CFG_READBACK_EN adds a registered shadow/active readback port.
module dds_cfg_scheduler
  import dds_cfg_pkg::*;
#(
  parameter int               CHANNELS     = 16,
  parameter int               CH_W         = $clog2(CHANNELS),
  parameter int               SYNC_TIMEOUT = 4096,
  parameter logic [OFF_W-1:0] RST_OFFSET   = 16'h0000
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      wr_valid,
  output logic                      wr_ready,
  input  logic [CH_W-1:0]           wr_chan,
  input  logic [1:0]                wr_field,
  input  logic [31:0]               wr_data,
  input  logic                      commit_valid,
  output logic                      commit_ready,
  input  logic                      commit_sync,
  input  logic                      commit_phclr,
  input  logic                      sync_tick,
  output logic [CHANNELS*FCW_W-1:0] act_fcw,
  output logic [CHANNELS*PCW_W-1:0] act_pcw,
  output logic [CHANNELS*AMP_W-1:0] act_amp,
  output logic [CHANNELS*OFF_W-1:0] act_off,
  output logic                      update_strb,
  output logic                      phase_clr,
  output logic [CHANNELS-1:0]       dirty,
  output logic                      busy,
  output logic                      timeout_err,
  output logic                      cfg_err
`ifdef DDS_CFG_READBACK_EN
  ,
  input  logic [CH_W-1:0]           rd_chan,
  input  logic [1:0]                rd_field,
  input  logic                      rd_sel_act,
  output logic [31:0]               rd_data
`endif
);

  localparam int CNT_W = $clog2(SYNC_TIMEOUT + 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] sync_cnt;
  logic             phclr_q;
  logic             idle, apply, commit_acc, wr_acc, wr_in_range, timeout_hit;

  chan_cfg_t        active_cfg [CHANNELS];
`ifdef DDS_CFG_READBACK_EN
  chan_cfg_t        shadow_cfg [CHANNELS];
`endif

  assign idle         = (state_q == ST_IDLE);
  assign apply        = (state_q == ST_APPLY);
  assign wr_ready     = idle;
  assign commit_ready = idle;
  assign busy         = !idle;
  assign commit_acc   = idle && commit_valid;
  assign wr_acc       = idle && wr_valid;
  assign wr_in_range  = (32'(wr_chan) < CHANNELS);
  assign timeout_hit  = (sync_cnt == CNT_W'(SYNC_TIMEOUT - 1));

  // NOTE: next-state is defaulted first so no path through the case infers a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:      if (commit_acc) state_d = commit_sync ? ST_WAIT_SYNC : ST_APPLY;
      ST_WAIT_SYNC: if (sync_tick || timeout_hit) state_d = ST_APPLY;
      ST_APPLY:     state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      sync_cnt    <= '0;
      phclr_q     <= 1'b0;
      timeout_err <= 1'b0;
      cfg_err     <= 1'b0;
      update_strb <= 1'b0;
      phase_clr   <= 1'b0;
    end else begin
      state_q     <= state_d;
      sync_cnt    <= (state_q == ST_WAIT_SYNC) ? sync_cnt + CNT_W'(1) : '0;
      update_strb <= apply;
      phase_clr   <= apply && phclr_q;
      if (commit_acc) begin
        phclr_q     <= commit_phclr;
        timeout_err <= 1'b0;
        cfg_err     <= 1'b0;
      end
      // A tick arriving on the last wait cycle still counts as a normal synced apply.
      if ((state_q == ST_WAIT_SYNC) && !sync_tick && timeout_hit) timeout_err <= 1'b1;
      // A bad write riding with a commit belongs to that commit, so its error survives the clear.
      if (wr_acc && !wr_in_range) cfg_err <= 1'b1;
    end
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_bank
    dds_cfg_bank #(
      .RST_OFFSET(RST_OFFSET)
    ) u_bank (
      .clk      (clk),
      .rst      (rst),
      .wr_en    (wr_acc && (wr_chan == CH_W'(c))),
      .wr_field (field_e'(wr_field)),
      .wr_data  (wr_data),
      .apply    (apply),
`ifdef DDS_CFG_READBACK_EN
      .shadow   (shadow_cfg[c]),
`endif
      .active   (active_cfg[c]),
      .dirty    (dirty[c])
    );

    assign act_fcw[c*FCW_W +: FCW_W] = active_cfg[c].fcw;
    assign act_pcw[c*PCW_W +: PCW_W] = active_cfg[c].pcw;
    assign act_amp[c*AMP_W +: AMP_W] = active_cfg[c].amp;
    assign act_off[c*OFF_W +: OFF_W] = active_cfg[c].off;
  end

`ifdef DDS_CFG_READBACK_EN
  chan_cfg_t rd_cfg;

  always_comb begin
    rd_cfg = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (rd_chan == CH_W'(c)) rd_cfg = rd_sel_act ? active_cfg[c] : shadow_cfg[c];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rd_data <= '0;
    else     rd_data <= cfg_field(rd_cfg, field_e'(rd_field));
  end
`endif

endmodule

// File: tb/tb_dds_cfg_scheduler.sv
// Bench for dds_cfg_scheduler: directed literal checks plus randomized traffic against
// an edge-scheduled transaction model compared on every falling clock edge.
module tb_dds_cfg_scheduler;
  import dds_cfg_pkg::*;

  localparam int          CH   = 12;
  localparam int          CHW  = 4;
  localparam int          TO   = 16;
  localparam logic [15:0] ROFF = 16'h8000;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              wr_valid = 1'b0;
  logic              wr_ready;
  logic [CHW-1:0]    wr_chan = '0;
  logic [1:0]        wr_field = '0;
  logic [31:0]       wr_data = '0;
  logic              commit_valid = 1'b0;
  logic              commit_ready;
  logic              commit_sync = 1'b0;
  logic              commit_phclr = 1'b0;
  logic              sync_tick = 1'b0;
  logic [CH*32-1:0]  act_fcw;
  logic [CH*10-1:0]  act_pcw;
  logic [CH*16-1:0]  act_amp;
  logic [CH*16-1:0]  act_off;
  logic              update_strb, phase_clr, busy, timeout_err, cfg_err;
  logic [CH-1:0]     dirty;

  dds_cfg_scheduler #(
    .CHANNELS(CH), .CH_W(CHW), .SYNC_TIMEOUT(TO), .RST_OFFSET(ROFF)
  ) dut (
    .clk(clk), .rst(rst),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_chan(wr_chan),
    .wr_field(wr_field), .wr_data(wr_data),
    .commit_valid(commit_valid), .commit_ready(commit_ready),
    .commit_sync(commit_sync), .commit_phclr(commit_phclr), .sync_tick(sync_tick),
    .act_fcw(act_fcw), .act_pcw(act_pcw), .act_amp(act_amp), .act_off(act_off),
    .update_strb(update_strb), .phase_clr(phase_clr), .dirty(dirty),
    .busy(busy), .timeout_err(timeout_err), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [383:0] got, input logic [383:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Reference model: shadow/active tables plus the edge at which a pending apply lands.
  logic [31:0]   m_sh_fcw [CH], m_act_fcw [CH];
  logic [9:0]    m_sh_pcw [CH], m_act_pcw [CH];
  logic [15:0]   m_sh_amp [CH], m_act_amp [CH];
  logic [15:0]   m_sh_off [CH], m_act_off [CH];
  logic [CH-1:0] m_dirty;
  bit            m_waiting, m_phclr, m_strobe, m_ph, m_terr, m_cerr;
  int            m_e0, m_apply_edge, edge_n;

  task automatic model_reset();
    for (int c = 0; c < CH; c++) begin
      m_sh_fcw[c] = '0; m_act_fcw[c] = '0;
      m_sh_pcw[c] = '0; m_act_pcw[c] = '0;
      m_sh_amp[c] = '0; m_act_amp[c] = '0;
      m_sh_off[c] = ROFF; m_act_off[c] = ROFF;
    end
    m_dirty = '0; m_waiting = 0; m_phclr = 0; m_strobe = 0; m_ph = 0;
    m_terr = 0; m_cerr = 0; m_apply_edge = -1;
  endtask

  task automatic model_edge();
    bit idle_before;
    idle_before = !m_waiting && (m_apply_edge < 0);
    edge_n++;
    m_strobe = 0;
    m_ph = 0;
    if (m_apply_edge == edge_n) begin
      for (int c = 0; c < CH; c++) begin
        if (m_dirty[c]) begin
          m_act_fcw[c] = m_sh_fcw[c]; m_act_pcw[c] = m_sh_pcw[c];
          m_act_amp[c] = m_sh_amp[c]; m_act_off[c] = m_sh_off[c];
        end
      end
      m_dirty = '0; m_strobe = 1; m_ph = m_phclr; m_apply_edge = -1;
    end else if (m_waiting) begin
      if (sync_tick) begin
        m_waiting = 0; m_apply_edge = edge_n + 1;
      end else if (edge_n - m_e0 == TO) begin
        m_waiting = 0; m_apply_edge = edge_n + 1; m_terr = 1;
      end
    end else if (idle_before) begin
      if (commit_valid) begin
        m_terr = 0; m_cerr = 0; m_phclr = commit_phclr;
        if (commit_sync) begin m_waiting = 1; m_e0 = edge_n; end
        else m_apply_edge = edge_n + 1;
      end
      if (wr_valid) begin
        if (int'(wr_chan) < CH) begin
          case (wr_field)
            2'd0: m_sh_fcw[wr_chan] = wr_data;
            2'd1: m_sh_pcw[wr_chan] = wr_data[9:0];
            2'd2: m_sh_amp[wr_chan] = wr_data[15:0];
            default: m_sh_off[wr_chan] = wr_data[15:0];
          endcase
          m_dirty[wr_chan] = 1'b1;
        end else begin
          m_cerr = 1;
        end
      end
    end
  endtask

  always @(negedge clk) begin : cmp
    logic [CH*32-1:0] e_fcw;
    logic [CH*10-1:0] e_pcw;
    logic [CH*16-1:0] e_amp, e_off;
    bit               m_idle;
    if (chk_en && !rst) begin
      for (int c = 0; c < CH; c++) begin
        e_fcw[c*32 +: 32] = m_act_fcw[c];
        e_pcw[c*10 +: 10] = m_act_pcw[c];
        e_amp[c*16 +: 16] = m_act_amp[c];
        e_off[c*16 +: 16] = m_act_off[c];
      end
      m_idle = !m_waiting && (m_apply_edge < 0);
      check("act_fcw", act_fcw, e_fcw);
      check("act_pcw", act_pcw, e_pcw);
      check("act_amp", act_amp, e_amp);
      check("act_off", act_off, e_off);
      check("update_strb", update_strb, m_strobe);
      check("phase_clr", phase_clr, m_ph);
      check("dirty", dirty, m_dirty);
      check("busy", busy, !m_idle);
      check("wr_ready", wr_ready, m_idle);
      check("commit_ready", commit_ready, m_idle);
      check("timeout_err", timeout_err, m_terr);
      check("cfg_err", cfg_err, m_cerr);
    end
  end

  task automatic step();
    @(posedge clk);
    if (!rst) model_edge();
    #1;
  endtask

  task automatic idle_inputs();
    wr_valid = 0; commit_valid = 0; commit_sync = 0; commit_phclr = 0; sync_tick = 0;
  endtask

  task automatic set_write(input int ch, input field_e f, input logic [31:0] d);
    wr_valid = 1; wr_chan = CHW'(ch); wr_field = f; wr_data = d;
  endtask

  task automatic do_reset();
    idle_inputs();
    #2 rst = 1;
    model_reset();
    @(posedge clk);
    #2 rst = 0;
  endtask

  initial begin
    int n;
    idle_inputs();
    model_reset();
    edge_n = 0;
    #12 rst = 0;
    chk_en = 1;
    step();
    check("rst_act_fcw", act_fcw, '0);
    check("rst_act_off", act_off, {CH{ROFF}});
    check("rst_dirty", dirty, '0);
    check("rst_ready", {wr_ready, commit_ready, busy}, 3'b110);

    // Immediate commit of ch3 FCW.
    set_write(3, FLD_FCW, 32'h0100_0000);
    step(); idle_inputs();
    check("t1_dirty3", dirty, 12'h008);
    commit_valid = 1;
    step(); idle_inputs();
    check("t1_not_yet", act_fcw[3*32 +: 32], 32'h0);
    step();
    check("t1_fcw3", act_fcw[3*32 +: 32], 32'h0100_0000);
    check("t1_all_fcw", act_fcw, 384'h0100_0000 << 96);
    check("t1_strb", update_strb, 1'b1);
    check("t1_dirty_clr", dirty, '0);
    step();
    check("t1_strb_once", update_strb, 1'b0);

    // Sync commit with a tick in the accept cycle (ignored), real tick 10 cycles later.
    set_write(0, FLD_AMP, 32'h0000_4000);
    commit_valid = 1; commit_sync = 1; sync_tick = 1;
    step(); idle_inputs();
    for (int i = 0; i < 9; i++) begin
      check("t2_wr_ready", wr_ready, 1'b0);
      check("t2_commit_ready", commit_ready, 1'b0);
      step();
    end
    sync_tick = 1;
    step(); sync_tick = 0;
    check("t2_not_yet", act_amp[15:0], 16'h0);
    step();
    check("t2_amp0", act_amp[15:0], 16'h4000);
    check("t2_strb", update_strb, 1'b1);
    step();

    // Sync commit that never sees a tick: forced apply.
    commit_valid = 1; commit_sync = 1;
    step(); idle_inputs();
    n = 0;
    while (!update_strb && n < 40) begin step(); n++; end
    check("t3_latency", 32'(n), 32'd17);
    check("t3_terr", timeout_err, 1'b1);
    commit_valid = 1;
    step(); idle_inputs();
    check("t3_terr_clr", timeout_err, 1'b0);
    step(); step();

    // Write and commit in the same cycle, with phase clear.
    set_write(5, FLD_PCW, 32'h0000_0155);
    commit_valid = 1; commit_phclr = 1;
    step(); idle_inputs();
    step();
    check("t4_pcw5", act_pcw[5*10 +: 10], 10'h155);
    check("t4_phclr", {phase_clr, update_strb}, 2'b11);
    step();
    check("t4_phclr_once", phase_clr, 1'b0);

    // Out-of-range writes, then a commit with nothing dirty.
    set_write(15, FLD_FCW, 32'hDEAD_BEEF);
    step();
    set_write(12, FLD_OFFSET, 32'h0000_7777);
    step(); idle_inputs();
    check("t5_cfg_err", cfg_err, 1'b1);
    check("t5_dirty", dirty, '0);
    commit_valid = 1;
    step(); idle_inputs();
    check("t5_cfg_err_clr", cfg_err, 1'b0);
    step();
    check("t5_strb", update_strb, 1'b1);
    check("t5_fcw_same", act_fcw, 384'h0100_0000 << 96);

    // Reset in the middle of a sync wait.
    set_write(2, FLD_OFFSET, 32'h0000_1111);
    step(); idle_inputs();
    commit_valid = 1; commit_sync = 1;
    step(); idle_inputs();
    step(); step();
    check("t6_busy", busy, 1'b1);
    #2 rst = 1;
    model_reset();
    #1;
    check("t6_busy_rst", busy, 1'b0);
    check("t6_dirty_rst", dirty, '0);
    check("t6_fcw_rst", act_fcw, '0);
    check("t6_off_rst", act_off, {CH{ROFF}});
    @(posedge clk);
    #2 rst = 0;

    // Randomized traffic against the model.
    for (int i = 0; i < 2000; i++) begin
      wr_valid     = ($urandom_range(0, 1) == 1);
      wr_chan      = CHW'($urandom_range(0, 15));
      wr_field     = 2'($urandom_range(0, 3));
      wr_data      = $urandom();
      commit_valid = ($urandom_range(0, 7) == 0);
      commit_sync  = ($urandom_range(0, 1) == 1);
      commit_phclr = ($urandom_range(0, 1) == 1);
      sync_tick    = ($urandom_range(0, 19) == 0);
      if (i == 1000) do_reset();
      step();
    end

    idle_inputs();
    step(); step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
